// File: rtl/cv32e40p_obi_data_responder.sv
// OBI data-side memory responder: byte-enabled word RAM behind a programmable grant delay
// and a fixed-latency, fully pipelined response path.
module cv32e40p_obi_data_responder #(
   parameter int unsigned ADDR_MEM_WIDTH = 13,
   parameter int unsigned GNT_DELAY      = 0,
   parameter int unsigned RESP_LAT       = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned Words = 2 ** (ADDR_MEM_WIDTH - 2);
   localparam int unsigned CntW  = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(GNT_DELAY);

   typedef enum logic {StIdle, StWait} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;

   logic                err;
   logic                accept;
   logic [ADDR_MEM_WIDTH-3:0] idx;
   logic [31:0]         rd_word;
   logic                unused_bits;

   logic [31:0]         mem [Words];

   logic [RESP_LAT-1:0] vld_q;
   logic [RESP_LAT-1:0] err_q;
   logic [31:0]         data_q [RESP_LAT];

   // Grant FSM; a zero delay bypasses it entirely and grants combinationally.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_o   = 1'b0;
      if (GNT_DELAY == 0) begin
         gnt_o   = req_i;
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_i) begin
                  state_d = StWait;
                  cnt_d   = CntW'(1);
               end
            end
            StWait: begin
               if (!req_i) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (cnt_q == CntMax) begin
                  gnt_o   = 1'b1;
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
      if (rst_i) begin
         gnt_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign err         = |addr_i[31:ADDR_MEM_WIDTH];
   assign idx         = addr_i[ADDR_MEM_WIDTH-1:2];
   assign accept      = req_i & gnt_o;
   assign unused_bits = ^addr_i[1:0];

   // Writes and out-of-range accesses return zero data so idle pipeline slots stay all-zero.
   assign rd_word = (accept && !we_i && !err) ? mem[idx] : 32'h0;

   always_ff @(posedge clk_i) begin
      if (accept && we_i && !err) begin
         for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
               mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= '0;
         err_q <= '0;
         for (int unsigned i = 0; i < RESP_LAT; i++) begin
            data_q[i] <= 32'h0;
         end
      end else begin
         vld_q[0]  <= accept;
         err_q[0]  <= accept & err;
         data_q[0] <= rd_word;
         for (int unsigned i = 1; i < RESP_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            err_q[i]  <= err_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   end

   assign rvalid_o = vld_q[RESP_LAT-1];
   assign err_o    = err_q[RESP_LAT-1];
   assign rdata_o  = data_q[RESP_LAT-1];

endmodule

// File: tb/tb_cv32e40p_obi_data_responder.sv
// Directed bench for the OBI data responder; four instances cover the grant-delay and
// response-latency configurations exercised below.
module tb_cv32e40p_obi_data_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req    [4];
   logic        gnt    [4];
   logic [31:0] addr   [4];
   logic        we     [4];
   logic [3:0]  be     [4];
   logic [31:0] wdata  [4];
   logic        rvalid [4];
   logic [31:0] rdata  [4];
   logic        err    [4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cv32e40p_obi_data_responder #(.ADDR_MEM_WIDTH(13), .GNT_DELAY(0), .RESP_LAT(1)) u0 (
      .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
      .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .err_o(err[0]));

   cv32e40p_obi_data_responder #(.ADDR_MEM_WIDTH(13), .GNT_DELAY(3), .RESP_LAT(2)) u1 (
      .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
      .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .err_o(err[1]));

   cv32e40p_obi_data_responder #(.ADDR_MEM_WIDTH(13), .GNT_DELAY(0), .RESP_LAT(3)) u2 (
      .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
      .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
      .rdata_o(rdata[2]), .err_o(err[2]));

   cv32e40p_obi_data_responder #(.ADDR_MEM_WIDTH(13), .GNT_DELAY(2), .RESP_LAT(8)) u3 (
      .clk_i(clk), .rst_i(rst), .req_i(req[3]), .gnt_o(gnt[3]), .addr_i(addr[3]),
      .we_i(we[3]), .be_i(be[3]), .wdata_i(wdata[3]), .rvalid_o(rvalid[3]),
      .rdata_o(rdata[3]), .err_o(err[3]));

   task automatic drive(input int u, input logic r, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d);
      req[u]   = r;
      addr[u]  = a;
      we[u]    = w;
      be[u]    = b;
      wdata[u] = d;
   endtask

   task automatic idle(input int u);
      drive(u, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int u = 0; u < 4; u++) idle(u);
      tick();
      tick();
      smp();
      for (int u = 0; u < 4; u++) begin
         checks++;
         if ({gnt[u], rvalid[u], err[u], rdata[u]} !== 35'h0) begin
            errors++;
            $display("FAIL reset u%0d: got g=%b v=%b e=%b d=%h want all zero",
                     u, gnt[u], rvalid[u], err[u], rdata[u]);
         end
      end
      tick();
      rst = 1'b0;
   endtask

   // Write then read 0x40 with same-cycle grant and one-cycle response.
   task automatic test_basic();
      logic eg, ev;
      logic [31:0] ed;
      for (int c = 0; c < 4; c++) begin
         tick();
         case (c)
            0: drive(0, 1'b1, 32'h40, 1'b1, 4'hF, 32'hDEADBEEF);
            1: drive(0, 1'b1, 32'h40, 1'b0, 4'hF, 32'h0);
            default: idle(0);
         endcase
         eg = (c < 2);
         ev = (c == 1) || (c == 2);
         ed = (c == 2) ? 32'hDEADBEEF : 32'h0;
         smp();
         checks++;
         if ({gnt[0], rvalid[0], err[0], rdata[0]} !== {eg, ev, 1'b0, ed}) begin
            errors++;
            $display("FAIL basic c%0d: got g=%b v=%b e=%b d=%h want g=%b v=%b e=0 d=%h",
                     c, gnt[0], rvalid[0], err[0], rdata[0], eg, ev, ed);
         end
      end
   endtask

   // Partial byte enables, then an all-zero enable that must leave the word untouched.
   task automatic test_byte_enable();
      logic eg, ev;
      logic [31:0] ed;
      for (int c = 0; c < 6; c++) begin
         tick();
         case (c)
            0: drive(0, 1'b1, 32'h80, 1'b1, 4'hF, 32'h11223344);
            1: drive(0, 1'b1, 32'h80, 1'b1, 4'h5, 32'hAABBCCDD);
            2: drive(0, 1'b1, 32'h80, 1'b1, 4'h0, 32'hFFFFFFFF);
            3: drive(0, 1'b1, 32'h80, 1'b0, 4'hF, 32'h0);
            default: idle(0);
         endcase
         eg = (c < 4);
         ev = (c >= 1) && (c <= 4);
         ed = (c == 4) ? 32'h11BB33DD : 32'h0;
         smp();
         checks++;
         if ({gnt[0], rvalid[0], err[0], rdata[0]} !== {eg, ev, 1'b0, ed}) begin
            errors++;
            $display("FAIL byte_en c%0d: got g=%b v=%b e=%b d=%h want g=%b v=%b e=0 d=%h",
                     c, gnt[0], rvalid[0], err[0], rdata[0], eg, ev, ed);
         end
      end
   endtask

   // 0x2000 would alias word 0 if the high address bits were ignored.
   task automatic test_out_of_range();
      logic eg, ev, ee;
      logic [31:0] ed;
      for (int c = 0; c < 6; c++) begin
         tick();
         case (c)
            0: drive(0, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0BADF00D);
            1: drive(0, 1'b1, 32'h2000, 1'b1, 4'hF, 32'hFFFFFFFF);
            2: drive(0, 1'b1, 32'h2000, 1'b0, 4'hF, 32'h0);
            3: drive(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
            default: idle(0);
         endcase
         eg = (c < 4);
         ev = (c >= 1) && (c <= 4);
         ee = (c == 2) || (c == 3);
         ed = (c == 4) ? 32'h0BADF00D : 32'h0;
         smp();
         checks++;
         if ({gnt[0], rvalid[0], err[0], rdata[0]} !== {eg, ev, ee, ed}) begin
            errors++;
            $display("FAIL out_of_range c%0d: got g=%b v=%b e=%b d=%h want g=%b v=%b e=%b d=%h",
                     c, gnt[0], rvalid[0], err[0], rdata[0], eg, ev, ee, ed);
         end
      end
   endtask

   // GNT_DELAY=3, RESP_LAT=2: grants at 3 and 7, responses at 5 and 9.
   task automatic test_grant_delay();
      logic eg, ev;
      logic [31:0] ed;
      for (int c = 0; c < 11; c++) begin
         tick();
         if (c < 4)      drive(1, 1'b1, 32'h100, 1'b1, 4'hF, 32'h12345678);
         else if (c < 8) drive(1, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
         else            idle(1);
         eg = (c == 3) || (c == 7);
         ev = (c == 5) || (c == 9);
         ed = (c == 9) ? 32'h12345678 : 32'h0;
         smp();
         checks++;
         if ({gnt[1], rvalid[1], err[1], rdata[1]} !== {eg, ev, 1'b0, ed}) begin
            errors++;
            $display("FAIL grant_delay c%0d: got g=%b v=%b e=%b d=%h want g=%b v=%b e=0 d=%h",
                     c, gnt[1], rvalid[1], err[1], rdata[1], eg, ev, ed);
         end
      end
   endtask

   // Four writes then four reads back to back with RESP_LAT=3.
   task automatic test_back_to_back();
      logic eg, ev;
      logic [31:0] ed;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (c < 4)
            drive(2, 1'b1, 32'(4 * c), 1'b1, 4'hF, 32'hC0DE0000 + 32'(c) * 32'h1111);
         else if (c < 8)
            drive(2, 1'b1, 32'(4 * (c - 4)), 1'b0, 4'hF, 32'h0);
         else
            idle(2);
         eg = (c < 8);
         ev = (c >= 3) && (c <= 10);
         ed = (c >= 7 && c <= 10) ? 32'hC0DE0000 + 32'(c - 7) * 32'h1111 : 32'h0;
         smp();
         checks++;
         if ({gnt[2], rvalid[2], err[2], rdata[2]} !== {eg, ev, 1'b0, ed}) begin
            errors++;
            $display("FAIL back_to_back c%0d: got g=%b v=%b e=%b d=%h want g=%b v=%b e=0 d=%h",
                     c, gnt[2], rvalid[2], err[2], rdata[2], eg, ev, ed);
         end
      end
   endtask

   // GNT_DELAY=2, RESP_LAT=8: grants at 2 and 5 are flushed by a reset in cycle 7 (FSM in
   // WAIT); the delay restarts from IDLE, granting at 10 with its response at 18 only.
   task automatic test_reset_inflight();
      logic eg, ev;
      for (int c = 0; c < 20; c++) begin
         tick();
         rst = (c == 7);
         if (c <= 10) drive(3, 1'b1, 32'h10, 1'b1, 4'hF, 32'h55AA55AA);
         else         idle(3);
         eg = (c == 2) || (c == 5) || (c == 10);
         ev = (c == 18);
         smp();
         checks++;
         if ({gnt[3], rvalid[3], err[3], rdata[3]} !== {eg, ev, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_inflight c%0d: got g=%b v=%b e=%b d=%h want g=%b v=%b e=0 d=0",
                     c, gnt[3], rvalid[3], err[3], rdata[3], eg, ev);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_enable();
      test_out_of_range();
      test_grant_delay();
      test_back_to_back();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
